update_scheduler: RTL and testbench
===================================

UPDATE_SCHEDULER -- requirements
Module: update_scheduler

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: width of config address and sequence read address.
REQ-002 Parameter DATA_WIDTH, default 16: width of config data and period register.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset is synchronous and active-low.
REQ-005 write_config_n  input  1  active-low config write strobe, one cycle per write.
REQ-006 config_address  input  ADDR_WIDTH  config register select.
REQ-007 config_data  input  DATA_WIDTH  config write data.
REQ-008 timer_enable  input  1  level; high = run update cycles.
REQ-009 read_address  output  ADDR_WIDTH  current sequence memory address presented to drivers.
REQ-010 step  output  1  one-cycle pulse; drivers latch data at read_address.
REQ-011 update_cycle_complete  output  1  one-cycle pulse coincident with the step that reads end address.
REQ-012 running  output  1  high while in RUN state.
REQ-013 pass_count  output  8  completed passes since last IDLE→RUN entry, wraps 255→0.

Function
REQ-014 Config map: addr 0 = PERIOD[DATA_WIDTH-1:0]; addr 1 = START[ADDR_WIDTH-1:0]; addr 2 = END[ADDR_WIDTH-1:0]; other addresses ignored, no side effect.
REQ-015 Config write takes effect at the edge where write_config_n is sampled low; writes are accepted in any state.
REQ-016 States: IDLE, RUN; IDLE→RUN when timer_enable sampled high; RUN→IDLE when timer_enable sampled low.
REQ-017 On IDLE→RUN: prescale counter loads PERIOD, read_address loads START, pass_count clears.
REQ-018 In RUN, counter decrements each cycle; step asserts in the cycle counter equals 0; counter reloads PERIOD on that cycle's edge.
REQ-019 Step spacing is PERIOD+1 cycles; PERIOD=0 gives step every cycle while RUN.
REQ-020 First step occurs PERIOD+1 cycles after the edge at which timer_enable is first sampled high.
REQ-021 On step edge: if read_address==END, read_address←START, update_cycle_complete high that cycle, pass_count increments; else read_address←read_address+1 mod 2^ADDR_WIDTH.
REQ-022 END<START: pass runs START..max, wraps to 0, continues to END.
REQ-023 PERIOD write during RUN used at next reload; START write used at next wrap; END compare always uses current register.
REQ-024 Config write in the same cycle as IDLE→RUN: new value is the one loaded.
REQ-025 timer_enable falling mid-pass: no further step, read_address returns to START on IDLE entry, pass_count holds.
REQ-026 step, update_cycle_complete low at all times outside RUN.

Reset
REQ-027 reset_n low at a rising edge: state IDLE, PERIOD=0, START=0, END=0, counter=0, read_address=0, pass_count=0, step=0, update_cycle_complete=0, running=0.
REQ-028 Reset overrides simultaneous config write and timer_enable.
REQ-029 Reset mid-RUN aborts immediately; no pulse issued in the reset cycle.

Structure
REQ-030 Shared package holds config register address constants and state encoding constants.
REQ-031 Prescale down-counter with reload and zero flag is one sub-module, step_prescaler.
REQ-032 All outputs driven from registers or decode of registered state only.

Verification
REQ-033 PERIOD=3, START=5, END=7, enable held -> step at cycles 4,8,12,16; read_address 5,6,7,5; update_cycle_complete with the step at 7; pass_count=1.
REQ-034 PERIOD=0, START=1022, END=1 -> step every cycle, addresses 1022,1023,0,1,1022; complete pulse on address 1.
REQ-035 Enable dropped after 2 steps, re-raised -> read_address restarts at START, pass_count 0, first step PERIOD+1 cycles later.
REQ-036 PERIOD 3→9 written mid-RUN -> current interval unchanged, following interval 10 cycles.
REQ-037 reset_n low mid-RUN with counter=1 -> no step, all outputs 0 next cycle, config registers 0.
REQ-038 Write to addr 3 and addr 1023 -> PERIOD/START/END unchanged, stepping unaffected.

Source files
------------

// File: rtl/update_scheduler_pkg.sv
// Shared constants for the update scheduler:
// config register map and controller state encoding.
package update_scheduler_pkg;

  localparam int unsigned CFG_PERIOD = 0;
  localparam int unsigned CFG_START  = 1;
  localparam int unsigned CFG_END    = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/step_prescaler.sv
// Prescale down-counter: loads on demand, counts down
// while enabled and reloads itself when it reaches zero.
module step_prescaler
  import update_scheduler_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             count_en,
  input  logic [WIDTH-1:0] reload_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // explicit load wins; otherwise count down and wrap
  // back to the reload value on the zero cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= reload_value;
    end else if (count_en) begin
      if (count == '0) begin
        count <= reload_value;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  // zero flag straight from the count register
  always_comb begin
    zero = (count == '0);
  end

endmodule

// File: rtl/update_scheduler.sv
// Walks sequence memory from START to END, one step
// every PERIOD+1 cycles while timer_enable is high.
module update_scheduler
  import update_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write_config_n,
  input  logic [ADDR_WIDTH-1:0] config_address,
  input  logic [DATA_WIDTH-1:0] config_data,
  input  logic                  timer_enable,
  output logic [ADDR_WIDTH-1:0] read_address,
  output logic                  step,
  output logic                  update_cycle_complete,
  output logic                  running,
  output logic [7:0]            pass_count
);

  state_t state;
  state_t state_next;

  logic [DATA_WIDTH-1:0] period_q;
  logic [ADDR_WIDTH-1:0] start_q;
  logic [ADDR_WIDTH-1:0] end_q;

  logic                  wr_period;
  logic                  wr_start;
  logic                  wr_end;
  logic [DATA_WIDTH-1:0] period_eff;
  logic [ADDR_WIDTH-1:0] start_eff;

  logic start_run;
  logic stop_run;
  logic zero;
  logic at_end;

  // config address decode; unmapped addresses
  // fall through to no write at all
  always_comb begin
    wr_period = 1'b0;
    wr_start  = 1'b0;
    wr_end    = 1'b0;
    unique case (1'b1)
      !write_config_n &&
      (config_address == ADDR_WIDTH'(CFG_PERIOD)):
        wr_period = 1'b1;
      !write_config_n &&
      (config_address == ADDR_WIDTH'(CFG_START)):
        wr_start = 1'b1;
      !write_config_n &&
      (config_address == ADDR_WIDTH'(CFG_END)):
        wr_end = 1'b1;
      default: ;
    endcase
  end

  // config registers, writable in any state
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      period_q <= '0;
      start_q  <= '0;
      end_q    <= '0;
    end else begin
      if (wr_period) period_q <= config_data;
      if (wr_start)  start_q  <= ADDR_WIDTH'(config_data);
      if (wr_end)    end_q    <= ADDR_WIDTH'(config_data);
    end
  end

  // loads see a write landing on the same edge
  always_comb begin
    period_eff = wr_period ? config_data : period_q;
    start_eff  = wr_start
               ? ADDR_WIDTH'(config_data) : start_q;
  end

  // state register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next state and run/stop transition strobes
  always_comb begin
    state_next = state;
    start_run  = 1'b0;
    stop_run   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (timer_enable) begin
          state_next = ST_RUN;
          start_run  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!timer_enable) begin
          state_next = ST_IDLE;
          stop_run   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  step_prescaler #(
    .WIDTH (DATA_WIDTH)
  ) u_prescaler (
    .clock        (clock),
    .reset_n      (reset_n),
    .load         (start_run),
    .count_en     (state == ST_RUN),
    .reload_value (period_eff),
    .zero         (zero)
  );

  // outputs decoded from registered state only
  always_comb begin
    running = (state == ST_RUN);
    step    = running && zero;
    at_end  = (read_address == end_q);
    update_cycle_complete = step && at_end;
  end

  // sequence address and pass counter
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      read_address <= '0;
      pass_count   <= '0;
    end else if (start_run) begin
      read_address <= start_eff;
      pass_count   <= '0;
    end else if (stop_run) begin
      read_address <= start_eff;
    end else if (step) begin
      if (at_end) begin
        read_address <= start_eff;
        pass_count   <= pass_count + 8'd1;
      end else begin
        read_address <= read_address + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_update_scheduler.sv
// Directed bench for update_scheduler: hand-computed
// step timing, addresses, passes, reset behaviour.
module tb_update_scheduler;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       write_config_n = 1'b1;
  logic [9:0] config_address = '0;
  logic [15:0] config_data = '0;
  logic       timer_enable = 1'b0;
  logic [9:0] read_address;
  logic       step;
  logic       update_cycle_complete;
  logic       running;
  logic [7:0] pass_count;

  int n_cmp = 0;
  int n_bad = 0;

  int seq1 [5] = '{5, 6, 7, 5, 6};
  int seq2 [5] = '{1022, 1023, 0, 1, 1022};

  update_scheduler #(
    .ADDR_WIDTH (10),
    .DATA_WIDTH (16)
  ) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .write_config_n        (write_config_n),
    .config_address        (config_address),
    .config_data           (config_data),
    .timer_enable          (timer_enable),
    .read_address          (read_address),
    .step                  (step),
    .update_cycle_complete (update_cycle_complete),
    .running               (running),
    .pass_count            (pass_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic cfg(input int a, input int d);
    write_config_n = 1'b0;
    config_address = 10'(a);
    config_data    = 16'(d);
    tick();
    write_config_n = 1'b1;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_step", 32'(step), 0);
    chk("rst_cmpl", 32'(update_cycle_complete), 0);
    chk("rst_run", 32'(running), 0);
    chk("rst_addr", 32'(read_address), 0);
    chk("rst_pass", 32'(pass_count), 0);
    reset_n = 1'b1;
    tick();

    // PERIOD=3 START=5 END=7
    cfg(0, 3);
    cfg(1, 5);
    cfg(2, 7);
    timer_enable = 1'b1;
    tick();
    chk("t1_run", 32'(running), 1);
    chk("t1_addr0", 32'(read_address), 5);
    chk("t1_step0", 32'(step), 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("t1_step", 32'(step), 32'(i % 4 == 3));
      chk("t1_addr", 32'(read_address), seq1[i / 4]);
      chk("t1_cmpl", 32'(update_cycle_complete),
          32'(i == 11));
      chk("t1_pass", 32'(pass_count), 32'(i >= 12));
    end
    timer_enable = 1'b0;
    tick();
    chk("t1_idle", 32'(running), 0);
    chk("t1_iaddr", 32'(read_address), 5);
    chk("t1_ipass", 32'(pass_count), 1);

    // PERIOD=0, wrap through top of address space
    cfg(0, 0);
    cfg(1, 1022);
    cfg(2, 1);
    timer_enable = 1'b1;
    tick();
    for (int i = 0; i <= 4; i++) begin
      chk("t2_step", 32'(step), 1);
      chk("t2_addr", 32'(read_address), seq2[i]);
      chk("t2_cmpl", 32'(update_cycle_complete),
          32'(i == 3));
      chk("t2_pass", 32'(pass_count), 32'(i == 4));
      tick();
    end
    timer_enable = 1'b0;
    tick();
    chk("t2_idle_step", 32'(step), 0);

    // drop enable after two steps, then restart
    cfg(0, 2);
    cfg(1, 10);
    cfg(2, 20);
    timer_enable = 1'b1;
    tick();
    chk("t3_pass0", 32'(pass_count), 0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("t3_step", 32'(step), 32'(i == 2 || i == 5));
    end
    chk("t3_addr", 32'(read_address), 12);
    timer_enable = 1'b0;
    tick();
    chk("t3_off_run", 32'(running), 0);
    chk("t3_off_step", 32'(step), 0);
    chk("t3_off_addr", 32'(read_address), 10);
    tick();
    timer_enable = 1'b1;
    tick();
    chk("t3_re_run", 32'(running), 1);
    chk("t3_re_addr", 32'(read_address), 10);
    chk("t3_re_pass", 32'(pass_count), 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t3_re_step", 32'(step), 32'(i == 2));
    end
    chk("t3_re_addr1", 32'(read_address), 11);
    timer_enable = 1'b0;
    tick();

    // PERIOD 3->9 mid-run, plus unmapped writes
    cfg(0, 3);
    cfg(1, 0);
    cfg(2, 100);
    timer_enable = 1'b1;
    tick();
    for (int i = 1; i <= 28; i++) begin
      if (i == 5) begin
        write_config_n = 1'b0;
        config_address = 10'd0;
        config_data    = 16'd9;
      end
      if (i == 9) begin
        write_config_n = 1'b0;
        config_address = 10'd3;
        config_data    = 16'd0;
      end
      if (i == 11) begin
        write_config_n = 1'b0;
        config_address = 10'd1023;
        config_data    = 16'd1;
      end
      tick();
      write_config_n = 1'b1;
      chk("t4_step", 32'(step),
          32'(i == 3 || i == 7 || i == 17 || i == 27));
    end
    chk("t4_addr", 32'(read_address), 4);
    for (int i = 29; i <= 36; i++) begin
      tick();
      chk("t4_quiet", 32'(step), 0);
    end

    // reset with counter at 1, colliding config write
    reset_n        = 1'b0;
    write_config_n = 1'b0;
    config_address = 10'd0;
    config_data    = 16'd5;
    tick();
    write_config_n = 1'b1;
    chk("t5_step", 32'(step), 0);
    chk("t5_cmpl", 32'(update_cycle_complete), 0);
    chk("t5_run", 32'(running), 0);
    chk("t5_addr", 32'(read_address), 0);
    chk("t5_pass", 32'(pass_count), 0);
    reset_n = 1'b1;
    tick();
    chk("t5_run1", 32'(running), 1);
    chk("t5_step1", 32'(step), 1);
    chk("t5_addr1", 32'(read_address), 0);
    chk("t5_cmpl1", 32'(update_cycle_complete), 1);
    tick();
    chk("t5_pass2", 32'(pass_count), 1);
    chk("t5_step2", 32'(step), 1);
    timer_enable = 1'b0;
    tick();
    chk("t5_off_step", 32'(step), 0);
    chk("t5_off_cmpl", 32'(update_cycle_complete), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
